// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, receiver state encoding and a width helper
//               for the buffered UART receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_PAR     = 3'd3,
      ST_STOP    = 3'd4,
      ST_WAIT_HI = 3'd5
   } rx_state_t;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word fall-through receive FIFO with occupancy count and
//               an overflow strobe for pushes refused while full.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         ovf
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_cw = $clog2(DEPTH + 1);
   localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
   localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
   localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_cw-1:0]  r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty = (r_count == '0);
   assign full  = (r_count == c_depth);
   assign count = r_count;

   // A pop in the same cycle frees the slot, so a push into a full FIFO is
   // only refused when no pop accompanies it.
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);
   assign ovf       = push & full & ~w_do_pop;

   // Output is forced to zero while empty so reset shows a clean head word.
   assign dout = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffered
// Description : Oversampling UART receiver feeding an error-tagged FIFO.
//               Define UART_RX_BREAK_DET_EN to add the brk_det output.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buffered
   import uart_pkg::*;
#(
   parameter int D_W       = 8,
   parameter int B_TICK    = 16,
   parameter int DEPTH     = 64,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         b_clk,
   input  logic                         rx_data,
   output logic                         b_en,
   input  logic                         rd_en,
   output logic [D_W-1:0]               ff_data_out,
   output logic                         ff_par_err,
   output logic                         ff_frm_err,
   output logic                         ff_empty,
   output logic                         ff_full,
   output logic [$clog2(DEPTH+1)-1:0]   ff_count,
   output logic                         ovr_err,
   input  logic                         ovr_clr
`ifdef UART_RX_BREAK_DET_EN
   ,
   output logic                         brk_det
`endif
);

   localparam int c_tw = cnt_width(B_TICK);
   localparam int c_bw = cnt_width(D_W);
   localparam logic [c_tw-1:0] c_tick_one  = c_tw'(1);
   localparam logic [c_tw-1:0] c_half_m1   = c_tw'(B_TICK / 2 - 1);
   localparam logic [c_tw-1:0] c_full_m1   = c_tw'(B_TICK - 1);
   localparam logic [c_bw-1:0] c_bit_one   = c_bw'(1);
   localparam logic [c_bw-1:0] c_last_bit  = c_bw'(D_W - 1);
   localparam logic            c_last_stop = (STOP_BITS == 2);
   localparam logic            c_odd       = (PARITY == PAR_ODD);

   logic            r_rx_meta;
   logic            r_rx_sync;
   rx_state_t       r_state,    w_state;
   logic [c_tw-1:0] r_tick,     w_tick;
   logic [c_bw-1:0] r_bit,      w_bit;
   logic [D_W-1:0]  r_shift,    w_shift;
   logic            r_par_err,  w_par_err;
   logic            r_frm_err,  w_frm_err;
   logic            r_stop_cnt, w_stop_cnt;
   logic            r_ovr_err;
   logic            w_push;
   logic            w_ovf;
   logic [D_W+1:0]  w_head;
`ifdef UART_RX_BREAK_DET_EN
   logic            r_par_zero, w_par_zero;
   logic            r_stop_lo,  w_stop_lo;
   logic            r_brk_det,  w_brk_det;
   assign brk_det = r_brk_det;
`endif

   assign b_en = (r_state != ST_IDLE);

   always_comb begin
      w_state    = r_state;
      w_tick     = r_tick;
      w_bit      = r_bit;
      w_shift    = r_shift;
      w_par_err  = r_par_err;
      w_frm_err  = r_frm_err;
      w_stop_cnt = r_stop_cnt;
      w_push     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      w_par_zero = r_par_zero;
      w_stop_lo  = r_stop_lo;
      w_brk_det  = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (!r_rx_sync) begin
               w_state = ST_START;
               w_tick  = '0;
            end
         end
         ST_START: begin
            if (b_clk) begin
               if (r_tick == c_half_m1) begin
                  // Line back high at mid start bit: treat as a glitch.
                  if (r_rx_sync) begin
                     w_state = ST_IDLE;
                  end else begin
                     w_state = ST_DATA;
                     w_tick  = '0;
                     w_bit   = '0;
                  end
               end else begin
                  w_tick = r_tick + c_tick_one;
               end
            end
         end
         ST_DATA: begin
            if (b_clk) begin
               if (r_tick == c_full_m1) begin
                  w_tick  = '0;
                  w_shift = {r_rx_sync, r_shift[D_W-1:1]};
                  if (r_bit == c_last_bit) begin
                     w_state    = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                     w_par_err  = 1'b0;
                     w_frm_err  = 1'b0;
                     w_stop_cnt = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                     w_par_zero = 1'b1;
                     w_stop_lo  = 1'b1;
`endif
                  end else begin
                     w_bit = r_bit + c_bit_one;
                  end
               end else begin
                  w_tick = r_tick + c_tick_one;
               end
            end
         end
         ST_PAR: begin
            if (b_clk) begin
               if (r_tick == c_full_m1) begin
                  w_tick    = '0;
                  w_par_err = ((^r_shift) ^ r_rx_sync) != c_odd;
`ifdef UART_RX_BREAK_DET_EN
                  w_par_zero = ~r_rx_sync;
`endif
                  w_state   = ST_STOP;
               end else begin
                  w_tick = r_tick + c_tick_one;
               end
            end
         end
         ST_STOP: begin
            if (b_clk) begin
               if (r_tick == c_full_m1) begin
                  w_tick    = '0;
                  w_frm_err = r_frm_err | ~r_rx_sync;
`ifdef UART_RX_BREAK_DET_EN
                  w_stop_lo = r_stop_lo & ~r_rx_sync;
`endif
                  if (r_stop_cnt == c_last_stop) begin
`ifdef UART_RX_BREAK_DET_EN
                     if ((r_shift == '0) && r_par_zero && w_stop_lo) begin
                        w_brk_det = 1'b1;
                        w_state   = ST_WAIT_HI;
                     end else begin
                        w_push  = 1'b1;
                        w_state = w_frm_err ? ST_WAIT_HI : ST_IDLE;
                     end
`else
                     w_push  = 1'b1;
                     w_state = w_frm_err ? ST_WAIT_HI : ST_IDLE;
`endif
                  end else begin
                     w_stop_cnt = 1'b1;
                  end
               end else begin
                  w_tick = r_tick + c_tick_one;
               end
            end
         end
         ST_WAIT_HI: begin
            if (r_rx_sync) begin
               w_state = ST_IDLE;
            end
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_meta  <= 1'b1;
         r_rx_sync  <= 1'b1;
         r_state    <= ST_IDLE;
         r_tick     <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_par_err  <= 1'b0;
         r_frm_err  <= 1'b0;
         r_stop_cnt <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         r_par_zero <= 1'b1;
         r_stop_lo  <= 1'b1;
         r_brk_det  <= 1'b0;
`endif
      end else begin
         r_rx_meta  <= rx_data;
         r_rx_sync  <= r_rx_meta;
         r_state    <= w_state;
         r_tick     <= w_tick;
         r_bit      <= w_bit;
         r_shift    <= w_shift;
         r_par_err  <= w_par_err;
         r_frm_err  <= w_frm_err;
         r_stop_cnt <= w_stop_cnt;
`ifdef UART_RX_BREAK_DET_EN
         r_par_zero <= w_par_zero;
         r_stop_lo  <= w_stop_lo;
         r_brk_det  <= w_brk_det;
`endif
      end
   end

   // Sticky overrun: a new overrun outranks a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovr_err <= 1'b0;
      end else if (w_ovf) begin
         r_ovr_err <= 1'b1;
      end else if (ovr_clr) begin
         r_ovr_err <= 1'b0;
      end
   end

   assign ovr_err = r_ovr_err;

   uart_rx_fifo #(
      .WIDTH (D_W + 2),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .din   ({w_frm_err, r_par_err, r_shift}),
      .pop   (rd_en),
      .dout  (w_head),
      .empty (ff_empty),
      .full  (ff_full),
      .count (ff_count),
      .ovf   (w_ovf)
   );

   assign ff_frm_err  = w_head[D_W+1];
   assign ff_par_err  = w_head[D_W];
   assign ff_data_out = w_head[D_W-1:0];

endmodule
`default_nettype wire
